mult_booth: RTL and testbench



---
 rtl/mult_pkg.sv | 13 +
 rtl/booth_step.sv | 37 +++
 rtl/mult_booth.sv | 129 ++++++++++++
 tb/tb_mult_booth.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the Booth multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mult_state_e;

    localparam int MULT_ITER  = 32;
    localparam int MULT_CNT_W = 5;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth step (add/sub then arithmetic shift)
//
// Ports:
//   acc_i  [WIDTH:0]   accumulator before the step (one guard bit)
//   q_i    [WIDTH-1:0] multiplier/low product register before the step
//   q1_i               bit shifted out of Q on the previous step
//   m_i    [WIDTH:0]   sign-extended multiplicand
//   acc_o, q_o, q1_o   values after add/sub and the 1-bit arithmetic shift
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc_i;
        case ({q_i[0], q1_i})
            2'b01:   sum = acc_i + m_i;
            2'b10:   sum = acc_i - m_i;
            default: sum = acc_i;
        endcase
    end

    // {sum, Q, q_1} >>> 1 with the accumulator sign bit replicated
    assign acc_o = {sum[WIDTH], sum[WIDTH:1]};
    assign q_o   = {sum[0], q_i[WIDTH-1:1]};
    assign q1_o  = q_i[0];

endmodule

// File: rtl/mult_booth.sv
// rtl/mult_booth.sv - sequential signed multiplier, fixed 33-cycle radix-2 Booth
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   start          multiply request, sampled only in IDLE
//   a, b           signed multiplicand / multiplier, captured on the start edge
//   hi, lo         registered product bits [2W-1:W] and [W-1:0]
//   busy           high while stepping (RUN)
//   done           one-cycle pulse when the product is available (DONE)
module mult_booth
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam logic [MULT_CNT_W-1:0] LAST_CNT = MULT_CNT_W'(MULT_ITER - 1);

    mult_state_e state_q, state_d;

    // ACC carries a guard bit so -M is exact when a is the most negative value
    logic [WIDTH:0]          acc_q, acc_d;
    logic [WIDTH:0]          m_q, m_d;
    logic [WIDTH-1:0]        q_q, q_d;
    logic                    qm1_q, qm1_d;
    logic [MULT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]        hi_q, hi_d;
    logic [WIDTH-1:0]        lo_q, lo_d;

    logic [WIDTH:0]          step_acc;
    logic [WIDTH-1:0]        step_q;
    logic                    step_qm1;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .q1_i  (qm1_q),
        .m_i   (m_q),
        .acc_o (step_acc),
        .q_o   (step_q),
        .q1_o  (step_qm1)
    );

    // State register and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        acc_d = acc_q;
        m_d   = m_q;
        q_d   = q_q;
        qm1_d = qm1_q;
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d   = {a[WIDTH-1], a};
                    acc_d = '0;
                    q_d   = b;
                    qm1_d = 1'b0;
                    cnt_d = '0;
                end
            end
            RUN: begin
                acc_d = step_acc;
                q_d   = step_q;
                qm1_d = step_qm1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    hi_d = step_acc[WIDTH-1:0];
                    lo_d = step_q;
                end
            end
            default: ;
        endcase
    end

    // Moore outputs
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_mult_booth.sv
// tb/tb_mult_booth.sv - directed self-checking bench for mult_booth
module tb_mult_booth;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [63:0] last_prod = '0;

    mult_booth #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One multiply; with disturb set, operands change and start pulses at E10
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] exp, input bit disturb);
        int cyc;
        int busy_n;
        int hold_err;
        int extra;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        busy_n = 0;
        hold_err = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_n++;
            if ({hi, lo} !== last_prod) hold_err++;
            if (disturb && cyc == 10) begin
                a = 32'h5555_5555;
                b = 32'h0000_3039;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'd32);
        check({tag, "_hold"}, 64'(hold_err), 64'd0);
        check({tag, "_product"}, {hi, lo}, exp);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check({tag, "_quiet_after"}, 64'(extra), 64'd0);
        last_prod = exp;
    endtask

    initial begin
        int cyc;
        int hold_err;

        // Reset state
        #1;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("pos_3x4", 32'd3, 32'd4, 64'h0000_0000_0000_000C, 1'b0);
        run_op("neg1x1", 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("7xm3", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        run_op("min_sq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
        run_op("max_sq", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0);
        run_op("isolate_11x13", 32'd11, 32'd13, 64'h0000_0000_0000_008F, 1'b1);

        // Reset in the middle of a run, half a cycle after E15
        @(negedge clk);
        a = 32'd100;
        b = 32'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("midrun_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("midrun_reset_hilo", {hi, lo}, 64'd0);
        check("midrun_reset_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        last_prod = '0;
        run_op("after_reset_2xm5", 32'd2, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0);

        // Back-to-back with start held high
        @(negedge clk);
        a = 32'd6;
        b = 32'd7;
        start = 1'b1;
        @(negedge clk);
        a = 32'd0;
        b = 32'h1234_5678;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_first_latency", 64'(cyc), 64'd33);
        check("b2b_first_product", {hi, lo}, 64'd42);
        // DONE returns to IDLE unconditionally, so the held start is taken one edge later
        @(negedge clk);
        cyc = 1;
        hold_err = 0;
        check("b2b_idle_gap", {62'd0, busy, done}, 64'd0);
        while (!done && cyc < 40) begin
            if ({hi, lo} !== 64'd42) hold_err++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("b2b_done_spacing", 64'(cyc), 64'd34);
        check("b2b_hold_42", 64'(hold_err), 64'd0);
        check("b2b_second_product", {hi, lo}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
